bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter N, default 4, meaning: number of requesters sharing the buffered output line (2..8).
REQ-002 Parameter MAX_HOLD, default 8, meaning: maximum consecutive GRANT cycles before forced rotation (1..255).
REQ-003 CLK  input  1  single clock; all state changes occur on the rising edge.
REQ-004 RST_N  input  1  asynchronous, active-low reset.
REQ-005 REQ  input  N  per-requester request; bit i high means requester i wants the line.
REQ-006 DIN  input  N  per-requester data bit; only the owner's bit is forwarded.
REQ-007 GNT  output  N  one-hot grant, or all-zero; registered.
REQ-008 O  output  1  buffered shared line; registered copy of DIN[owner], or 0 when there is no owner.
REQ-009 BUSY  output  1  high in the GRANT and TURNAROUND states; registered.

Function
REQ-010 The block SHALL implement three states: IDLE, GRANT and TURNAROUND.
REQ-011 IDLE: if REQ is nonzero, the next state SHALL be GRANT with GNT one-hot set to the round-robin winner; otherwise the block SHALL stay in IDLE.
REQ-012 The round-robin winner SHALL be the first set REQ bit searching upward from (LAST+1) mod N, wrapping from N-1 to 0, where LAST is the previous owner index.
REQ-013 On entering GRANT, LAST SHALL be set to the winner and the hold counter to 1.
REQ-014 In each GRANT cycle, O SHALL be loaded with DIN[owner], giving one cycle of latency from DIN to O.
REQ-015 GRANT: if REQ[owner] is low, the next state SHALL be TURNAROUND.
REQ-016 GRANT: if the hold counter equals MAX_HOLD and any other REQ bit is high, the next state SHALL be TURNAROUND, even if REQ[owner] is still high.
REQ-017 GRANT: if the hold counter equals MAX_HOLD and no other requester is active, the block SHALL stay in GRANT with the counter saturated at MAX_HOLD.
REQ-018 GRANT otherwise: the block SHALL stay in GRANT and increment the hold counter.
REQ-019 TURNAROUND SHALL last exactly one cycle with GNT=0 and O=0 (dead cycle, no two drivers on the line).
REQ-020 After TURNAROUND the block SHALL arbitrate exactly as in IDLE.
REQ-021 GNT SHALL never have more than one bit set.
REQ-022 GNT SHALL never change directly from one nonzero value to a different nonzero value.
REQ-023 REQ bits that rise during GRANT SHALL not preempt the owner before REQ-016 applies.
REQ-024 When the owner's REQ falls in the same cycle that the hold counter reaches MAX_HOLD, the block SHALL go to TURNAROUND; the result is identical under REQ-015 and REQ-016.
REQ-025 REQ and DIN SHALL be sampled only at rising CLK edges; glitches between edges SHALL have no effect.

Reset
REQ-026 While RST_N is low, the block SHALL be in IDLE with GNT=0, O=0, BUSY=0, hold counter 0 and LAST=N-1, so requester 0 has first priority.
REQ-027 Reset asserted mid-GRANT SHALL clear GNT and O immediately (asynchronously), with no TURNAROUND cycle.
REQ-028 After reset deassertion, the first arbitration SHALL occur at the next rising CLK edge.

Structure
REQ-029 A shared package SHALL hold the state enumeration (IDLE, GRANT, TURNAROUND) and the default values of N and MAX_HOLD.
REQ-030 The round-robin search SHALL be a combinational sub-module rr_picker with inputs REQ and LAST, and outputs one-hot WIN and a VALID flag.
REQ-031 The O driver SHALL reuse the existing single-bit Buffer gate module on the registered data bit.

Verification
REQ-032 Reset, then REQ=0001, DIN[0]=1 -> edge 1: GNT=0001, BUSY=1; edge 2: O=1.
REQ-033 REQ=0101 held, MAX_HOLD=8 -> GNT=0001 for 8 cycles, 1 dead cycle, then GNT=0100 for 8 cycles, 1 dead cycle, then GNT=0001 again.
REQ-034 Owner 2 drops REQ while REQ=1011 and LAST=2 -> one TURNAROUND cycle (GNT=0, O=0), then GNT=1000 (wrap search order 3, 0, 1).
REQ-035 REQ=0010 alone for 20 cycles -> GNT=0010 continuously, hold counter saturates at 8, no TURNAROUND.
REQ-036 RST_N pulled low mid-GRANT with O=1 -> GNT=0, O=0 and BUSY=0 before the next CLK edge; after release, REQ=1111 -> GNT=0001.
REQ-037 A random REQ/DIN run of 10,000 cycles -> GNT is always one-hot or zero, every owner change passes through a zero cycle, and no active requester waits more than (N-1)*(MAX_HOLD+1) cycles.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the round-robin bus arbiter: controller states
// and the default sizing parameters.
package bus_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      GRANT      = 2'd1,
      TURNAROUND = 2'd2
   } arb_state_e;

   localparam int DEFAULT_N        = 4;
   localparam int DEFAULT_MAX_HOLD = 8;

endpackage

// File: rtl/bus_arbiter_buffer.sv
// Single-bit buffer gate that drives the shared output line.
module Buffer (
   input  logic a,
   output logic y
);

   assign y = a;

endmodule

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin search: finds the first set request bit
// starting just above the previous owner and wrapping from N-1 to 0.
module rr_picker #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic [N-1:0]  win,
   output logic          valid
);

   logic [IW-1:0] idx;

   // Walk candidates last+1 .. last+N (mod N) and keep the first hit only.
   always_comb begin
      win   = '0;
      valid = 1'b0;
      idx   = '0;
      for (int k = 1; k <= N; k++) begin
         idx = IW'((int'(last) + k) % N);
         if (!valid && req[idx]) begin
            win[idx] = 1'b1;
            valid    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for a shared single-bit line. An owner keeps the line
// for up to MAX_HOLD cycles while others wait; every hand-over passes through
// a one-cycle dead TURNAROUND so the line never has two drivers.
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int N        = DEFAULT_N,
   parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   input  logic [N-1:0] din,
   output logic [N-1:0] gnt,
   output logic         o,
   output logic         busy
);

   localparam int          IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [7:0]  MH = 8'(MAX_HOLD);

   arb_state_e    state_q, state_d;
   logic [N-1:0]  gnt_q, gnt_d;
   logic [IW-1:0] last_q, last_d;
   logic [7:0]    hold_q, hold_d;
   logic          o_q, o_d;
   logic          busy_q, busy_d;

   logic [N-1:0]  win;
   logic          valid;
   logic [IW-1:0] win_idx;
   logic          others_req;

   rr_picker #(.N(N), .IW(IW)) u_picker (
      .req   (req),
      .last  (last_q),
      .win   (win),
      .valid (valid)
   );

   // Convert the picker's one-hot winner into an owner index.
   always_comb begin
      win_idx = '0;
      for (int i = 0; i < N; i++) begin
         if (win[i]) win_idx = IW'(i);
      end
   end

   assign others_req = |(req & ~gnt_q);

   // Next-state and next-output logic for the IDLE/GRANT/TURNAROUND controller.
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      last_d  = last_q;
      hold_d  = hold_q;
      o_d     = 1'b0;
      case (state_q)
         IDLE, TURNAROUND: begin
            if (valid) begin
               state_d = GRANT;
               gnt_d   = win;
               last_d  = win_idx;
               hold_d  = 8'd1;
            end else begin
               state_d = IDLE;
               gnt_d   = '0;
               hold_d  = '0;
            end
         end
         GRANT: begin
            if (!req[last_q] || ((hold_q == MH) && others_req)) begin
               state_d = TURNAROUND;
               gnt_d   = '0;
               hold_d  = '0;
            end else begin
               o_d = din[last_q];
               if (hold_q != MH) hold_d = hold_q + 8'd1;
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
            hold_d  = '0;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // State and output registers; reset leaves requester 0 with first priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         last_q  <= IW'(N - 1);
         hold_q  <= '0;
         o_q     <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
         hold_q  <= hold_d;
         o_q     <= o_d;
         busy_q  <= busy_d;
      end
   end

   Buffer u_obuf (
      .a (o_q),
      .y (o)
   );

   assign gnt  = gnt_q;
   assign busy = busy_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios followed by a long
// randomized run, all compared against a behavioural ownership model.
module tb_bus_arbiter;

   localparam int N          = 4;
   localparam int MAX_HOLD   = 8;
   localparam int WAIT_BOUND = (N - 1) * (MAX_HOLD + 1);

   logic         clk;
   logic         rst_n;
   logic [N-1:0] req;
   logic [N-1:0] din;
   logic [N-1:0] gnt;
   logic         o;
   logic         busy;

   int n_cmp;
   int n_err;

   // Model: who owns the line, who owned it last, how long, and whether
   // the current cycle is the dead cycle after a release.
   int           m_owner;
   int           m_last;
   int           m_hold;
   bit           m_dead;
   logic         exp_o;
   logic [N-1:0] exp_gnt;
   logic         exp_busy;

   int           wait_cnt [N];
   logic [N-1:0] prev_gnt;

   bus_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .din   (din),
      .gnt   (gnt),
      .o     (o),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      n_cmp++;
      assert (observed === expected)
      else begin
         n_err++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic apply_stimulus(input logic [N-1:0] r, input logic [N-1:0] d);
      req = r;
      din = d;
   endtask

   function automatic void model_reset();
      m_owner  = -1;
      m_last   = N - 1;
      m_hold   = 0;
      m_dead   = 1'b0;
      exp_o    = 1'b0;
      exp_gnt  = '0;
      exp_busy = 1'b0;
      prev_gnt = '0;
      for (int i = 0; i < N; i++) wait_cnt[i] = 0;
   endfunction

   function automatic void model_step(input logic [N-1:0] r, input logic [N-1:0] d);
      logic [N-1:0] others;
      int           c;
      if (m_owner >= 0) begin
         others = r;
         others[m_owner] = 1'b0;
         if (!r[m_owner] || (m_hold == MAX_HOLD && others != '0)) begin
            m_owner = -1;
            m_dead  = 1'b1;
            exp_o   = 1'b0;
         end else begin
            exp_o = d[m_owner];
            if (m_hold < MAX_HOLD) m_hold++;
         end
      end else begin
         exp_o  = 1'b0;
         m_dead = 1'b0;
         for (int k = 1; k <= N; k++) begin
            c = (m_last + k) % N;
            if (m_owner < 0 && r[c]) begin
               m_owner = c;
               m_last  = c;
               m_hold  = 1;
            end
         end
      end
      exp_gnt  = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
      exp_busy = (m_owner >= 0) || m_dead;
   endfunction

   // One clock: inputs seen at the edge feed the model, outputs checked 1 ns later.
   task automatic tick();
      logic [N-1:0] r;
      logic [N-1:0] d;
      r = req;
      d = din;
      @(posedge clk);
      #1;
      model_step(r, d);
      check_output("gnt", 32'(gnt), 32'(exp_gnt));
      check_output("o", 32'(o), 32'(exp_o));
      check_output("busy", 32'(busy), 32'(exp_busy));
      check_output("onehot0", 32'($onehot0(gnt)), 32'd1);
      if (prev_gnt != '0 && gnt != '0) check_output("handover", 32'(gnt), 32'(prev_gnt));
      prev_gnt = gnt;
      for (int i = 0; i < N; i++) begin
         if (r[i] && !gnt[i]) wait_cnt[i]++;
         else wait_cnt[i] = 0;
         check_output("wait_bound", 32'(wait_cnt[i] <= WAIT_BOUND), 32'd1);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      apply_stimulus('0, '0);
      @(posedge clk);
      #1;
      check_output("rst_gnt", 32'(gnt), 32'd0);
      check_output("rst_o", 32'(o), 32'd0);
      check_output("rst_busy", 32'(busy), 32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [N-1:0] r;
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      apply_stimulus('0, '0);
      model_reset();
      $display("[TB] start");

      // First grant after reset and one-cycle data latency.
      do_reset();
      apply_stimulus(4'b0001, 4'b0001);
      tick();
      check_output("first_gnt", 32'(gnt), 32'b0001);
      check_output("first_busy", 32'(busy), 32'd1);
      tick();
      check_output("first_o", 32'(o), 32'd1);

      // Two contenders rotate after MAX_HOLD cycles with a dead cycle between.
      do_reset();
      apply_stimulus(4'b0101, 4'b0000);
      for (int i = 0; i < MAX_HOLD; i++) begin
         tick();
         check_output("rot_a", 32'(gnt), 32'b0001);
      end
      tick();
      check_output("rot_dead1", 32'(gnt), 32'd0);
      for (int i = 0; i < MAX_HOLD; i++) begin
         tick();
         check_output("rot_b", 32'(gnt), 32'b0100);
      end
      tick();
      check_output("rot_dead2", 32'(gnt), 32'd0);
      tick();
      check_output("rot_back", 32'(gnt), 32'b0001);

      // Owner 2 releases while 3, 1, 0 request: wrap order picks 3.
      do_reset();
      apply_stimulus(4'b0100, 4'b1111);
      tick();
      check_output("own2", 32'(gnt), 32'b0100);
      apply_stimulus(4'b1011, 4'b1111);
      tick();
      check_output("rel_gnt", 32'(gnt), 32'd0);
      check_output("rel_o", 32'(o), 32'd0);
      tick();
      check_output("wrap_gnt", 32'(gnt), 32'b1000);

      // Lone requester keeps the line past MAX_HOLD; glitches between edges ignored.
      do_reset();
      apply_stimulus(4'b0010, 4'b0010);
      for (int i = 0; i < 20; i++) begin
         tick();
         check_output("solo_gnt", 32'(gnt), 32'b0010);
      end
      req = 4'b0000;
      din = 4'b0000;
      #3;
      apply_stimulus(4'b0010, 4'b0010);
      tick();
      check_output("glitch_gnt", 32'(gnt), 32'b0010);
      check_output("glitch_o", 32'(o), 32'd1);

      // Asynchronous reset mid-grant clears outputs before the next edge.
      do_reset();
      apply_stimulus(4'b0001, 4'b0001);
      tick();
      tick();
      check_output("pre_rst_o", 32'(o), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check_output("async_gnt", 32'(gnt), 32'd0);
      check_output("async_o", 32'(o), 32'd0);
      check_output("async_busy", 32'(busy), 32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      apply_stimulus(4'b1111, 4'b0000);
      tick();
      check_output("post_rst_gnt", 32'(gnt), 32'b0001);

      // Long random run: sticky requests with occasional flips, random data.
      r = 4'b1111;
      for (int c = 0; c < 10000; c++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 9) == 0) r[i] = ~r[i];
         end
         apply_stimulus(r, N'($urandom));
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
